// File: rtl/behavioural_cache.sv
// Fixed-latency behavioural instruction/data memory model for core-level benches.
// Define BEHAVIOURAL_CACHE_ALIGN_CHECK_EN to make accepted misaligned accesses fatal.
module behavioural_cache #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_rd_en_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_rd_data_o,
  output logic        imem_busy_o,
  output logic        imem_rdy_o,
  input  logic        dmem_rd_en_i,
  input  logic        dmem_wr_en_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [1:0]  dmem_wr_size_i,
  input  logic [31:0] dmem_wr_data_i,
  output logic [31:0] dmem_rd_data_o,
  output logic        dmem_busy_o,
  output logic        dmem_rdy_o
);

  localparam logic [3:0] BUSY_CYCLES = 4'(LATENCY - 1);

  logic [7:0]  imem [0:65535];
  logic [7:0]  dmem [0:65535];

  logic [15:0] ia, ia1, ia2, ia3;
  logic [15:0] da, da1, da2, da3;
  logic [31:0] fetch_word, load_word;
  logic        i_accept, d_accept, d_write;

  logic [3:0]  i_cnt, d_cnt;
  logic [31:0] i_pend, d_pend;
  logic        d_pend_rd;

  always_comb begin
    ia  = imem_addr_i[15:0];
    ia1 = ia + 16'd1;
    ia2 = ia + 16'd2;
    ia3 = ia + 16'd3;
    da  = dmem_addr_i[15:0];
    da1 = da + 16'd1;
    da2 = da + 16'd2;
    da3 = da + 16'd3;
    fetch_word = {imem[ia], imem[ia1], imem[ia2], imem[ia3]};
    load_word  = {dmem[da3], dmem[da2], dmem[da1], dmem[da]};
    i_accept   = imem_rd_en_i & ~imem_busy_o;
    d_accept   = (dmem_rd_en_i | dmem_wr_en_i) & ~dmem_busy_o;
    d_write    = dmem_wr_en_i;
  end

  // Instruction channel: capture at acceptance, present after LATENCY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_busy_o    <= 1'b0;
      imem_rdy_o     <= 1'b0;
      imem_rd_data_o <= '0;
      i_cnt          <= '0;
      i_pend         <= '0;
    end else begin
      imem_rdy_o <= 1'b0;
      if (imem_busy_o) begin
        i_cnt <= i_cnt - 4'd1;
        if (i_cnt == 4'd1) begin
          imem_busy_o    <= 1'b0;
          imem_rdy_o     <= 1'b1;
          imem_rd_data_o <= i_pend;
        end
      end else if (i_accept) begin
`ifdef BEHAVIOURAL_CACHE_ALIGN_CHECK_EN
        if (ia[1:0] != 2'b00)
          $fatal(1, "behavioural_cache: misaligned fetch at 0x%08h", imem_addr_i);
`endif
        if (LATENCY == 1) begin
          imem_rdy_o     <= 1'b1;
          imem_rd_data_o <= fetch_word;
        end else begin
          imem_busy_o <= 1'b1;
          i_cnt       <= BUSY_CYCLES;
          i_pend      <= fetch_word;
        end
      end
    end
  end

  // Data channel: a write outranks a simultaneous read; only reads update rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_busy_o    <= 1'b0;
      dmem_rdy_o     <= 1'b0;
      dmem_rd_data_o <= '0;
      d_cnt          <= '0;
      d_pend         <= '0;
      d_pend_rd      <= 1'b0;
    end else begin
      dmem_rdy_o <= 1'b0;
      if (dmem_busy_o) begin
        d_cnt <= d_cnt - 4'd1;
        if (d_cnt == 4'd1) begin
          dmem_busy_o <= 1'b0;
          dmem_rdy_o  <= 1'b1;
          if (d_pend_rd)
            dmem_rd_data_o <= d_pend;
        end
      end else if (d_accept) begin
`ifdef BEHAVIOURAL_CACHE_ALIGN_CHECK_EN
        if ((d_write && dmem_wr_size_i == 2'd1 && da[0]) ||
            ((!d_write || dmem_wr_size_i[1]) && da[1:0] != 2'b00))
          $fatal(1, "behavioural_cache: misaligned data access at 0x%08h", dmem_addr_i);
`endif
        if (LATENCY == 1) begin
          dmem_rdy_o <= 1'b1;
          if (!d_write)
            dmem_rd_data_o <= load_word;
        end else begin
          dmem_busy_o <= 1'b1;
          d_cnt       <= BUSY_CYCLES;
          d_pend      <= load_word;
          d_pend_rd   <= !d_write;
        end
      end
    end
  end

  // Array update is not reset so preloaded and committed contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && d_accept && d_write) begin
      dmem[da] <= dmem_wr_data_i[7:0];
      if (dmem_wr_size_i != 2'd0)
        dmem[da1] <= dmem_wr_data_i[15:8];
      if (dmem_wr_size_i[1]) begin
        dmem[da2] <= dmem_wr_data_i[23:16];
        dmem[da3] <= dmem_wr_data_i[31:24];
      end
    end
  end

endmodule

// File: tb/tb_behavioural_cache.sv
// Directed self-checking bench for behavioural_cache at the default LATENCY of 2.
module tb_behavioural_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd_en_i;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_rd_data_o;
  logic        imem_busy_o, imem_rdy_o;
  logic        dmem_rd_en_i, dmem_wr_en_i;
  logic [31:0] dmem_addr_i;
  logic [1:0]  dmem_wr_size_i;
  logic [31:0] dmem_wr_data_i;
  logic [31:0] dmem_rd_data_o;
  logic        dmem_busy_o, dmem_rdy_o;

  int errors = 0;
  int checks = 0;

  behavioural_cache #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .imem_rd_en_i(imem_rd_en_i), .imem_addr_i(imem_addr_i),
    .imem_rd_data_o(imem_rd_data_o), .imem_busy_o(imem_busy_o), .imem_rdy_o(imem_rdy_o),
    .dmem_rd_en_i(dmem_rd_en_i), .dmem_wr_en_i(dmem_wr_en_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wr_size_i(dmem_wr_size_i), .dmem_wr_data_i(dmem_wr_data_i),
    .dmem_rd_data_o(dmem_rd_data_o), .dmem_busy_o(dmem_busy_o), .dmem_rdy_o(dmem_rdy_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    imem_rd_en_i = 0; imem_addr_i = '0;
    dmem_rd_en_i = 0; dmem_wr_en_i = 0; dmem_addr_i = '0;
    dmem_wr_size_i = '0; dmem_wr_data_i = '0;
    repeat (3) @(negedge clk);
    dut.imem[0] = 8'h13; dut.imem[1] = 8'h05; dut.imem[2] = 8'h10; dut.imem[3] = 8'h00;
    dut.imem[32] = 8'hAA; dut.imem[33] = 8'hBB; dut.imem[34] = 8'hCC; dut.imem[35] = 8'hDD;
    dut.dmem[64] = 8'h01; dut.dmem[65] = 8'h02; dut.dmem[66] = 8'h03; dut.dmem[67] = 8'h04;
    checks += 6;
    if (imem_busy_o !== 1'b0) begin errors++; $display("FAIL reset_imem_busy got %b want 0", imem_busy_o); end
    if (imem_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_imem_rdy got %b want 0", imem_rdy_o); end
    if (imem_rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_imem_data got %h want 0", imem_rd_data_o); end
    if (dmem_busy_o !== 1'b0) begin errors++; $display("FAIL reset_dmem_busy got %b want 0", dmem_busy_o); end
    if (dmem_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_dmem_rdy got %b want 0", dmem_rdy_o); end
    if (dmem_rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_dmem_data got %h want 0", dmem_rd_data_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    imem_rd_en_i = 1; imem_addr_i = 32'h0;
    @(negedge clk);
    imem_rd_en_i = 0;
    checks += 2;
    if (imem_busy_o !== 1'b1) begin errors++; $display("FAIL fetch_busy got %b want 1", imem_busy_o); end
    if (imem_rdy_o !== 1'b0) begin errors++; $display("FAIL fetch_early_rdy got %b want 0", imem_rdy_o); end
    @(negedge clk);
    checks += 3;
    if (imem_rdy_o !== 1'b1) begin errors++; $display("FAIL fetch_rdy got %b want 1", imem_rdy_o); end
    if (imem_busy_o !== 1'b0) begin errors++; $display("FAIL fetch_busy_end got %b want 0", imem_busy_o); end
    if (imem_rd_data_o !== 32'h13051000) begin errors++; $display("FAIL fetch_data got %h want 13051000", imem_rd_data_o); end
    @(negedge clk);
    checks += 2;
    if (imem_rdy_o !== 1'b0) begin errors++; $display("FAIL fetch_rdy_pulse got %b want 0", imem_rdy_o); end
    if (imem_rd_data_o !== 32'h13051000) begin errors++; $display("FAIL fetch_hold got %h want 13051000", imem_rd_data_o); end
  endtask

  task automatic test_data_rw();
    dmem_wr_en_i = 1; dmem_addr_i = 32'h100; dmem_wr_size_i = 2'd2; dmem_wr_data_i = 32'hDEADBEEF;
    @(negedge clk);
    dmem_wr_en_i = 0;
    checks += 1;
    if (dmem_busy_o !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", dmem_busy_o); end
    @(negedge clk);
    checks += 5;
    if (dmem_rdy_o !== 1'b1) begin errors++; $display("FAIL write_rdy got %b want 1", dmem_rdy_o); end
    if (dut.dmem[256] !== 8'hEF) begin errors++; $display("FAIL word_b0 got %h want EF", dut.dmem[256]); end
    if (dut.dmem[257] !== 8'hBE) begin errors++; $display("FAIL word_b1 got %h want BE", dut.dmem[257]); end
    if (dut.dmem[258] !== 8'hAD) begin errors++; $display("FAIL word_b2 got %h want AD", dut.dmem[258]); end
    if (dut.dmem[259] !== 8'hDE) begin errors++; $display("FAIL word_b3 got %h want DE", dut.dmem[259]); end
    // byte write issued in the rdy cycle is accepted immediately
    dmem_wr_en_i = 1; dmem_addr_i = 32'h101; dmem_wr_size_i = 2'd0; dmem_wr_data_i = 32'hFFFFFF55;
    @(negedge clk);
    dmem_wr_en_i = 0;
    @(negedge clk);
    checks += 4;
    if (dut.dmem[256] !== 8'hEF) begin errors++; $display("FAIL byte_b0 got %h want EF", dut.dmem[256]); end
    if (dut.dmem[257] !== 8'h55) begin errors++; $display("FAIL byte_b1 got %h want 55", dut.dmem[257]); end
    if (dut.dmem[258] !== 8'hAD) begin errors++; $display("FAIL byte_b2 got %h want AD", dut.dmem[258]); end
    if (dut.dmem[259] !== 8'hDE) begin errors++; $display("FAIL byte_b3 got %h want DE", dut.dmem[259]); end
    dmem_rd_en_i = 1; dmem_addr_i = 32'h100;
    @(negedge clk);
    dmem_rd_en_i = 0;
    @(negedge clk);
    checks += 2;
    if (dmem_rdy_o !== 1'b1) begin errors++; $display("FAIL read_rdy got %b want 1", dmem_rdy_o); end
    if (dmem_rd_data_o !== 32'hDEAD55EF) begin errors++; $display("FAIL read_data got %h want DEAD55EF", dmem_rd_data_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    dmem_rd_en_i = 1; dmem_addr_i = 32'h100;
    @(negedge clk);
    @(negedge clk);
    if (dmem_rdy_o) pulses++;
    dmem_rd_en_i = 0;
    repeat (4) begin
      @(negedge clk);
      if (dmem_rdy_o) pulses++;
    end
    checks += 1;
    if (pulses !== 1) begin errors++; $display("FAIL busy_reject_pulses got %0d want 1", pulses); end
    dmem_rd_en_i = 1;
    @(negedge clk);
    dmem_rd_en_i = 0;
    @(negedge clk);
    checks += 1;
    if (dmem_rdy_o !== 1'b1) begin errors++; $display("FAIL b2b_first_rdy got %b want 1", dmem_rdy_o); end
    dmem_rd_en_i = 1; dmem_addr_i = 32'h40;
    @(negedge clk);
    dmem_rd_en_i = 0;
    checks += 2;
    if (dmem_busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", dmem_busy_o); end
    if (dmem_rdy_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", dmem_rdy_o); end
    @(negedge clk);
    checks += 2;
    if (dmem_rdy_o !== 1'b1) begin errors++; $display("FAIL b2b_second_rdy got %b want 1", dmem_rdy_o); end
    if (dmem_rd_data_o !== 32'h04030201) begin errors++; $display("FAIL b2b_data got %h want 04030201", dmem_rd_data_o); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    dmem_wr_en_i = 1; dmem_addr_i = 32'h0000FFFF; dmem_wr_size_i = 2'd3; dmem_wr_data_i = 32'h11223344;
    @(negedge clk);
    dmem_wr_en_i = 0;
    @(negedge clk);
    checks += 4;
    if (dut.dmem[65535] !== 8'h44) begin errors++; $display("FAIL wrap_ffff got %h want 44", dut.dmem[65535]); end
    if (dut.dmem[0] !== 8'h33) begin errors++; $display("FAIL wrap_0 got %h want 33", dut.dmem[0]); end
    if (dut.dmem[1] !== 8'h22) begin errors++; $display("FAIL wrap_1 got %h want 22", dut.dmem[1]); end
    if (dut.dmem[2] !== 8'h11) begin errors++; $display("FAIL wrap_2 got %h want 11", dut.dmem[2]); end
    dmem_rd_en_i = 1;
    @(negedge clk);
    dmem_rd_en_i = 0;
    @(negedge clk);
    checks += 1;
    if (dmem_rd_data_o !== 32'h11223344) begin errors++; $display("FAIL wrap_read got %h want 11223344", dmem_rd_data_o); end
    @(negedge clk);
  endtask

  task automatic test_concurrent();
    imem_rd_en_i = 1; imem_addr_i = 32'h20;
    dmem_rd_en_i = 1; dmem_addr_i = 32'h40;
    @(negedge clk);
    imem_rd_en_i = 0; dmem_rd_en_i = 0;
    @(negedge clk);
    checks += 4;
    if (imem_rdy_o !== 1'b1) begin errors++; $display("FAIL conc_irdy got %b want 1", imem_rdy_o); end
    if (dmem_rdy_o !== 1'b1) begin errors++; $display("FAIL conc_drdy got %b want 1", dmem_rdy_o); end
    if (imem_rd_data_o !== 32'hAABBCCDD) begin errors++; $display("FAIL conc_idata got %h want AABBCCDD", imem_rd_data_o); end
    if (dmem_rd_data_o !== 32'h04030201) begin errors++; $display("FAIL conc_ddata got %h want 04030201", dmem_rd_data_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    dmem_wr_en_i = 1; dmem_addr_i = 32'h200; dmem_wr_size_i = 2'd2; dmem_wr_data_i = 32'hCAFEF00D;
    imem_rd_en_i = 1; imem_addr_i = 32'h0;
    @(negedge clk);
    dmem_wr_en_i = 0; imem_rd_en_i = 0;
    rst = 1'b1;
    @(negedge clk);
    checks += 6;
    if (dmem_busy_o !== 1'b0) begin errors++; $display("FAIL midrst_dbusy got %b want 0", dmem_busy_o); end
    if (dmem_rdy_o !== 1'b0) begin errors++; $display("FAIL midrst_drdy got %b want 0", dmem_rdy_o); end
    if (imem_busy_o !== 1'b0) begin errors++; $display("FAIL midrst_ibusy got %b want 0", imem_busy_o); end
    if (imem_rd_data_o !== 32'h0) begin errors++; $display("FAIL midrst_idata got %h want 0", imem_rd_data_o); end
    if (dut.dmem[512] !== 8'h0D) begin errors++; $display("FAIL midrst_commit0 got %h want 0D", dut.dmem[512]); end
    if (dut.dmem[515] !== 8'hCA) begin errors++; $display("FAIL midrst_commit3 got %h want CA", dut.dmem[515]); end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dmem_rdy_o || imem_rdy_o) pulses++;
    end
    checks += 1;
    if (pulses !== 0) begin errors++; $display("FAIL midrst_no_rdy got %0d want 0", pulses); end
    imem_rd_en_i = 1; imem_addr_i = 32'h0;
    @(negedge clk);
    imem_rd_en_i = 0;
    @(negedge clk);
    checks += 2;
    if (imem_rdy_o !== 1'b1) begin errors++; $display("FAIL survive_rdy got %b want 1", imem_rdy_o); end
    if (imem_rd_data_o !== 32'h13051000) begin errors++; $display("FAIL survive_data got %h want 13051000", imem_rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_rw();
    test_back_to_back();
    test_wrap();
    test_concurrent();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
